// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, start bit, 8 data + odd parity + stop, device ACK.
// Optional single retry on NACK/timeout when PS2_TX_RETRY_EN is defined.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned SYNC_STAGES    = 3
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned IW = $clog2(INHIBIT_CYCLES) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [IW-1:0] INH_END  = IW'(INHIBIT_CYCLES);
  localparam logic [TW-1:0] TMO_END  = TW'(TIMEOUT_CYCLES);
  localparam logic [3:0]    STOP_IDX = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_SEND, S_ACK, S_WAIT_IDLE, S_DONE, S_ERR
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev;
  logic                   sync_clk, sync_data, fall;

  logic [9:0]    frame_q;
  logic [3:0]    idx_q, idx_d;
  logic [IW-1:0] inh_cnt_q, inh_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          clk_oe_d, data_oe_d, ready_d, done_d, err_d;
  logic          accept, timeout, fail, retry_ok;

  // Pin synchronisers; lines idle high
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_in};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data_in};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign sync_clk  = clk_sync[SYNC_STAGES-1];
  assign sync_data = data_sync[SYNC_STAGES-1];
  assign fall      = clk_prev & ~sync_clk;
  assign accept    = (state_q == S_IDLE) && tx_valid && tx_ready;
  assign timeout   = (to_cnt_q == TMO_END);

`ifdef PS2_TX_RETRY_EN
  logic retried_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)                 retried_q <= 1'b0;
    else if (accept)           retried_q <= 1'b0;
    else if (fail && retry_ok) retried_q <= 1'b1;
  end

  assign retry_ok = ~retried_q;
`else
  assign retry_ok = 1'b0;
`endif

  // Frame is {stop, odd parity, d7..d0}, shifted out LSB first
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)       frame_q <= '0;
    else if (accept) frame_q <= {1'b1, ~^tx_data, tx_data};
  end

  always_comb begin
    state_d   = state_q;
    clk_oe_d  = ps2_clk_oe;
    data_oe_d = ps2_data_oe;
    idx_d     = idx_q;
    fail      = 1'b0;
    inh_cnt_d = '0;
    to_cnt_d  = '0;
    ready_d   = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_INHIBIT;
          clk_oe_d  = 1'b1;
          data_oe_d = 1'b0;
        end
      end
      S_INHIBIT: begin
        if (inh_cnt_q == INH_LAST) data_oe_d = 1'b1;
        if (inh_cnt_q == INH_END) begin
          clk_oe_d = 1'b0;
          idx_d    = 4'd0;
          state_d  = S_SEND;
        end
      end
      S_SEND: begin
        if (timeout) fail = 1'b1;
        else if (fall) begin
          data_oe_d = ~frame_q[idx_q];
          idx_d     = idx_q + 4'd1;
          if (idx_q == STOP_IDX) state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (timeout) fail = 1'b1;
        else if (fall) begin
          if (sync_data) fail = 1'b1;
          else           state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (timeout)                    fail    = 1'b1;
        else if (sync_clk && sync_data) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Failure releases both lines in the same cycle; a retry re-inhibits instead
    if (fail) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      state_d   = S_ERR;
      if (retry_ok) begin
        clk_oe_d = 1'b1;
        state_d  = S_INHIBIT;
      end
    end
    if (state_d == S_ERR) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
    end

    if (state_q == S_INHIBIT && state_d == S_INHIBIT)
      inh_cnt_d = (inh_cnt_q == INH_END) ? inh_cnt_q : inh_cnt_q + IW'(1);
    if (state_d == state_q && !fall)
      to_cnt_d = timeout ? to_cnt_q : to_cnt_q + TW'(1);

    ready_d = (state_d == S_IDLE);
    done_d  = (state_d == S_DONE);
    err_d   = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      inh_cnt_q   <= '0;
      to_cnt_q    <= '0;
      tx_ready    <= 1'b1;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      inh_cnt_q   <= inh_cnt_d;
      to_cnt_q    <= to_cnt_d;
      tx_ready    <= ready_d;
      tx_done     <= done_d;
      tx_err      <= err_d;
      ps2_clk_oe  <= clk_oe_d;
      ps2_data_oe <= data_oe_d;
    end
  end

endmodule
